// File: rtl/eth_sma_master_engine.sv
// Ethernet SMA (MDIO Clause 22) master protocol engine.
// Pops 23-bit commands from the SMA tx FIFO, serialises each one as a
// management frame on MDC/MDIO, and pushes 16-bit read data to the rx FIFO.
//
// Ports:
//   clk, rst             engine clock, async active-high reset
//   r_sma_en             enables command fetch
//   r_sma_clk_div        MDC half-period = r_sma_clk_div+1 clk cycles
//   r_sma_phy_addr       PHYAD used for every frame
//   tx_fifo_empty/re     tx FIFO status / 1-cycle pop
//   tx_fifo_rdata        command: [22] read, [21] no preamble,
//                        [20:16] REGAD, [15:0] write data
//   rx_fifo_full/we      rx FIFO status / 1-cycle push
//   rx_fifo_wdata        read data
//   mdc, mdio_o, mdio_oe management clock and MDIO output/enable
//   mdio_i               MDIO input
//   busy                 high from FETCH through DONE
//   int_status_xfer_done 1-cycle pulse per completed frame

module eth_sma_master_engine (
   input  logic        clk,
   input  logic        rst,
   input  logic        r_sma_en,
   input  logic [7:0]  r_sma_clk_div,
   input  logic [4:0]  r_sma_phy_addr,
   input  logic        tx_fifo_empty,
   output logic        tx_fifo_re,
   input  logic [22:0] tx_fifo_rdata,
   input  logic        rx_fifo_full,
   output logic        rx_fifo_we,
   output logic [15:0] rx_fifo_wdata,
   output logic        mdc,
   output logic        mdio_o,
   output logic        mdio_oe,
   input  logic        mdio_i,
   output logic        busy,
   output logic        int_status_xfer_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t      state_q;
   state_t      state_d;

   logic [63:0] frame_q;
   logic [5:0]  bit_cnt_q;
   logic [7:0]  half_cnt_q;
   logic [7:0]  div_q;
   logic        phase_q;
   logic        rd_q;
   logic [15:0] rdata_q;

   logic        half_end;
   logic        last_bit;
   logic        rise_cyc;
   logic        cmd_rd;
   logic        cmd_nopre;
   logic [31:0] hdr;
   logic [63:0] frame_d;

   assign half_end = (half_cnt_q == 8'd0);
   assign last_bit = (bit_cnt_q == 6'd0);
   // First clk cycle of the high half: the cycle MDC goes high.
   assign rise_cyc = phase_q && (half_cnt_q == div_q);

   assign cmd_rd    = tx_fifo_rdata[22];
   assign cmd_nopre = tx_fifo_rdata[21];

   // ST, OP, PHYAD, REGAD, TA, data. Read TA/data carry ones, since
   // the line is released there and mdio_o just idles high.
   assign hdr = {2'b01,
                 cmd_rd ? 2'b10 : 2'b01,
                 r_sma_phy_addr,
                 tx_fifo_rdata[20:16],
                 cmd_rd ? 2'b11 : 2'b10,
                 cmd_rd ? 16'hFFFF : tx_fifo_rdata[15:0]};

   // Frame is left-aligned and shifted out of bit 63.
   assign frame_d = cmd_nopre ? {hdr, 32'hFFFF_FFFF}
                              : {32'hFFFF_FFFF, hdr};

   assign rx_fifo_wdata = rdata_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d              = state_q;
      tx_fifo_re           = 1'b0;
      rx_fifo_we           = 1'b0;
      int_status_xfer_done = 1'b0;
      busy                 = 1'b1;
      mdc                  = 1'b0;
      mdio_o               = 1'b1;
      mdio_oe              = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (r_sma_en && !tx_fifo_empty && !rx_fifo_full)
               state_d = S_FETCH;
         end
         S_FETCH: begin
            tx_fifo_re = 1'b1;
            state_d    = S_LOAD;
         end
         S_LOAD: begin
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            mdc    = phase_q;
            mdio_o = frame_q[63];
            // Reads release the line for the last 18 bits (TA + data).
            mdio_oe = !rd_q || (bit_cnt_q > 6'd17);
            if (phase_q && half_end && last_bit)
               state_d = S_DONE;
         end
         S_DONE: begin
            int_status_xfer_done = 1'b1;
            rx_fifo_we           = rd_q;
            state_d              = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_q    <= '0;
         bit_cnt_q  <= '0;
         half_cnt_q <= '0;
         div_q      <= '0;
         phase_q    <= 1'b0;
         rd_q       <= 1'b0;
         rdata_q    <= '0;
      end else if (state_q == S_LOAD) begin
         frame_q    <= frame_d;
         bit_cnt_q  <= cmd_nopre ? 6'd31 : 6'd63;
         half_cnt_q <= r_sma_clk_div;
         div_q      <= r_sma_clk_div;
         phase_q    <= 1'b0;
         rd_q       <= cmd_rd;
      end else if (state_q == S_SHIFT) begin
         if (rise_cyc && rd_q && (bit_cnt_q < 6'd16))
            rdata_q <= {rdata_q[14:0], mdio_i};
         if (half_end) begin
            half_cnt_q <= div_q;
            phase_q    <= ~phase_q;
            // End of the high half: advance to the next bit.
            if (phase_q) begin
               frame_q <= {frame_q[62:0], 1'b1};
               if (!last_bit)
                  bit_cnt_q <= bit_cnt_q - 6'd1;
            end
         end else begin
            half_cnt_q <= half_cnt_q - 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_eth_sma_master_engine.sv
// Testbench for eth_sma_master_engine.
// Directed frames with a tx FIFO model, a PHY read-data model and a monitor.

module tb_eth_sma_master_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        r_sma_en = 1'b0;
   logic [7:0]  r_sma_clk_div = 8'd0;
   logic [4:0]  r_sma_phy_addr = 5'd0;
   logic        tx_fifo_empty;
   logic        tx_fifo_re;
   logic [22:0] tx_fifo_rdata;
   logic        rx_fifo_full = 1'b0;
   logic        rx_fifo_we;
   logic [15:0] rx_fifo_wdata;
   logic        mdc;
   logic        mdio_o;
   logic        mdio_oe;
   logic        mdio_i;
   logic        busy;
   logic        int_status_xfer_done;

   eth_sma_master_engine dut (
      .clk                  (clk),
      .rst                  (rst),
      .r_sma_en             (r_sma_en),
      .r_sma_clk_div        (r_sma_clk_div),
      .r_sma_phy_addr       (r_sma_phy_addr),
      .tx_fifo_empty        (tx_fifo_empty),
      .tx_fifo_re           (tx_fifo_re),
      .tx_fifo_rdata        (tx_fifo_rdata),
      .rx_fifo_full         (rx_fifo_full),
      .rx_fifo_we           (rx_fifo_we),
      .rx_fifo_wdata        (rx_fifo_wdata),
      .mdc                  (mdc),
      .mdio_o               (mdio_o),
      .mdio_oe              (mdio_oe),
      .mdio_i               (mdio_i),
      .busy                 (busy),
      .int_status_xfer_done (int_status_xfer_done)
   );

   always #5 clk = ~clk;

   // tx FIFO model
   logic [22:0] cmd_mem [16];
   int          wr_ptr = 0;
   int          rd_ptr = 0;

   assign tx_fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (tx_fifo_re) begin
         tx_fifo_rdata <= cmd_mem[rd_ptr % 16];
         rd_ptr        <= rd_ptr + 1;
      end
   end

   task automatic push(input logic [22:0] c);
      cmd_mem[wr_ptr % 16] = c;
      wr_ptr++;
   endtask

   // Monitor, sampled on the falling clk edge
   int          cyc = 0;
   int          re_cnt = 0;
   int          we_cnt = 0;
   int          done_cnt = 0;
   int          re_cyc = 0;
   int          done_cyc = 0;
   int          gap = 0;
   int          nb = 0;
   int          fall_cnt = 0;
   int          pmin = 0;
   int          pmax = 0;
   int          last_rise = -1;
   int          busy_len = 0;
   int          last_busy_len = 0;
   logic [63:0] fb = '0;
   logic [63:0] ob = '0;
   logic [15:0] wcap = '0;
   logic        busy_q = 1'b0;
   logic        mdc_q = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (busy && !busy_q) begin
         fb        = '0;
         ob        = '0;
         nb        = 0;
         fall_cnt  = 0;
         pmin      = 1000;
         pmax      = 0;
         last_rise = -1;
         busy_len  = 0;
      end
      if (busy)
         busy_len++;
      if (!busy && busy_q)
         last_busy_len = busy_len;
      if (mdc && !mdc_q) begin
         fb = {fb[62:0], mdio_o};
         ob = {ob[62:0], mdio_oe};
         nb++;
         if (last_rise >= 0) begin
            if (cyc - last_rise < pmin) pmin = cyc - last_rise;
            if (cyc - last_rise > pmax) pmax = cyc - last_rise;
         end
         last_rise = cyc;
      end
      if (!mdc && mdc_q)
         fall_cnt++;
      if (tx_fifo_re) begin
         if (done_cnt > 0) gap = cyc - done_cyc;
         re_cnt++;
         re_cyc = cyc;
      end
      if (rx_fifo_we) begin
         we_cnt++;
         wcap = rx_fifo_wdata;
      end
      if (int_status_xfer_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      busy_q = busy;
      mdc_q  = mdc;
   end

   // PHY model: drives phy_data on frame bits dbase..dbase+15
   logic [15:0] phy_data = 16'h0000;
   int          dbase = 1000;

   always_comb begin
      mdio_i = 1'b1;
      if (fall_cnt >= dbase && fall_cnt < dbase + 16)
         mdio_i = phy_data[4'(15 - (fall_cnt - dbase))];
   end

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic wait_done(input int n, input int budget);
      int k = 0;
      while (done_cnt < n && k < budget) begin
         tick();
         k++;
      end
      check("done_reached", 64'(done_cnt), 64'(n));
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) tick();
      check("rst_outs",
            {57'd0, tx_fifo_re, rx_fifo_we, mdc, mdio_o, mdio_oe,
             busy, int_status_xfer_done},
            64'b0001000);
      check("rst_wdata", 64'(rx_fifo_wdata), 64'h0);
      rst = 1'b0;
      tick();

      // Write, div=1, preamble on
      r_sma_clk_div  = 8'd1;
      r_sma_phy_addr = 5'h01;
      push(23'h0A1234);
      r_sma_en = 1'b1;
      wait_done(1, 400);
      repeat (3) tick();
      check("t1_frame", fb,
            {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h01, 5'h0A, 2'b10, 16'h1234});
      check("t1_oe", ob, 64'hFFFF_FFFF_FFFF_FFFF);
      check("t1_nbits", 64'(nb), 64'd64);
      check("t1_per_min", 64'(pmin), 64'd4);
      check("t1_per_max", 64'(pmax), 64'd4);
      check("t1_latency", 64'(done_cyc - re_cyc + 1), 64'd259);
      check("t1_busy_len", 64'(last_busy_len), 64'd259);
      check("t1_no_we", 64'(we_cnt), 64'd0);

      // Read, div=0, preamble on
      r_sma_clk_div  = 8'd0;
      r_sma_phy_addr = 5'h03;
      phy_data       = 16'hA5C3;
      dbase          = 48;
      push(23'h420000);
      wait_done(2, 300);
      repeat (3) tick();
      check("t2_hdr", 64'(fb[63:18]),
            64'({32'hFFFF_FFFF, 2'b01, 2'b10, 5'h03, 5'h02}));
      check("t2_oe", ob, 64'hFFFF_FFFF_FFFC_0000);
      check("t2_we_cnt", 64'(we_cnt), 64'd1);
      check("t2_rdata", 64'(wcap), 64'hA5C3);
      check("t2_latency", 64'(done_cyc - re_cyc + 1), 64'd131);

      // Read, preamble suppressed, div=0
      phy_data = 16'h5A3C;
      dbase    = 16;
      push(23'h650000);
      wait_done(3, 200);
      repeat (3) tick();
      check("t3_nbits", 64'(nb), 64'd32);
      check("t3_hdr", 64'(fb[31:18]),
            64'({2'b01, 2'b10, 5'h03, 5'h05}));
      check("t3_oe", 64'(ob[31:0]), 64'hFFFC_0000);
      check("t3_rdata", 64'(wcap), 64'h5A3C);
      check("t3_latency", 64'(done_cyc - re_cyc + 1), 64'd67);
      check("t3_busy_len", 64'(last_busy_len), 64'd67);

      // rx full blocks fetch; release gives back-to-back frames
      dbase        = 1000;
      rx_fifo_full = 1'b1;
      push(23'h210011);
      push(23'h22BEEF);
      repeat (20) tick();
      check("t4_blocked", 64'(re_cnt), 64'd3);
      rx_fifo_full = 1'b0;
      wait_done(5, 300);
      repeat (3) tick();
      check("t4_re_cnt", 64'(re_cnt), 64'd5);
      check("t4_gap", 64'(gap), 64'd2);
      check("t4_frame", 64'(fb[31:0]),
            64'({2'b01, 2'b01, 5'h03, 5'h02, 2'b10, 16'hBEEF}));
      check("t4_no_we", 64'(we_cnt), 64'd2);

      // Reset at bit 20 of a write frame
      push(23'h0A1234);
      begin
         int k = 0;
         while (!(busy && busy_q && nb >= 20) && k < 200) begin
            tick();
            k++;
         end
      end
      check("t5_reached", 64'(nb), 64'd20);
      rst = 1'b1;
      #1;
      check("t5_rst_outs", {60'd0, mdc, mdio_oe, busy, mdio_o},
            64'b0001);
      tick();
      rst = 1'b0;
      repeat (40) tick();
      check("t5_re_cnt", 64'(re_cnt), 64'd6);
      check("t5_done_cnt", 64'(done_cnt), 64'd5);
      check("t5_idle", {62'd0, busy, mdc}, 64'd0);

      // Enable gating
      r_sma_en = 1'b0;
      push(23'h210011);
      repeat (20) tick();
      check("t6_no_fetch", 64'(re_cnt), 64'd6);
      push(23'h22BEEF);
      r_sma_en = 1'b1;
      begin
         int k = 0;
         while (!busy && k < 20) begin
            tick();
            k++;
         end
      end
      repeat (10) tick();
      r_sma_en = 1'b0;
      wait_done(6, 200);
      repeat (20) tick();
      check("t6_re_cnt", 64'(re_cnt), 64'd7);
      check("t6_done_cnt", 64'(done_cnt), 64'd6);
      check("t6_fifo_left", 64'(tx_fifo_empty), 64'd0);
      check("t6_idle", 64'(busy), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
